// File: rtl/read_pointer_ctrl_pkg.sv
// Shared definitions for the read-side pointer controller of the asynchronous FIFO:
// default parameters and the binary/Gray helpers used by the pointer logic.
package read_pointer_ctrl_pkg;

  localparam int DEF_SIZE               = 4;
  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_ALMOST_EMPTY_LEVEL = 1;

  // Helpers work on a wide container so any SIZE up to 31 can reuse them.
  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

  function automatic int fifo_depth(input int size);
    return 1 << size;
  endfunction

  function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/read_pointer_ctrl_if.sv
// Consumer-facing bundle of the read-side controller: pop request, incoming Gray
// write pointer, and the address/flags/level/Gray pointer it produces.
interface read_pointer_ctrl_if #(
  parameter int SIZE = 4
) ();

  // read_inc is a pop request; it is accepted on a read_clk edge only when
  // read_empty is low at that edge, otherwise it is ignored without side effects.
  logic            read_inc;
  logic [SIZE:0]   write_pointer_grey;
  logic            read_empty;
  logic            read_almost_empty;
  logic [SIZE-1:0] read_address;
  logic [SIZE:0]   read_pointer;
  logic [SIZE:0]   read_level;

  modport master (
    output read_inc,
    output write_pointer_grey,
    input  read_empty,
    input  read_almost_empty,
    input  read_address,
    input  read_pointer,
    input  read_level
  );

  modport slave (
    input  read_inc,
    input  write_pointer_grey,
    output read_empty,
    output read_almost_empty,
    output read_address,
    output read_pointer,
    output read_level
  );

endinterface

// File: rtl/read_pointer_ctrl_gray2bin.sv
// Combinational Gray -> binary conversion for a SIZE+1 bit FIFO pointer.
module read_pointer_ctrl_gray2bin
  import read_pointer_ctrl_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic [SIZE:0] gray,
  output logic [SIZE:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin       = '0;
    bin[SIZE] = gray[SIZE];
    for (int i = SIZE - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/read_pointer_ctrl.sv
// Read-domain pointer/flag controller of the asynchronous FIFO: synchronises the Gray
// write pointer and maintains the read pointer, empty flags and occupancy.
module read_pointer_ctrl
  import read_pointer_ctrl_pkg::*;
#(
  parameter int SIZE               = DEF_SIZE,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int ALMOST_EMPTY_LEVEL = DEF_ALMOST_EMPTY_LEVEL
) (
  input  logic               read_clk,
  input  logic               read_reset,
  read_pointer_ctrl_if.slave bus
);

  localparam int            PW       = SIZE + 1;
  localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] wptr_bin;

  logic [PW-1:0] bin_q;
  logic [PW-1:0] gray_q;
  logic [PW-1:0] level_q;
  logic          empty_q;
  logic          almost_empty_q;

  logic          do_read;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] level_next;

  // Write-pointer synchroniser: the only flops that sample the asynchronous input.
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    if (i == 0) begin : g_first
      always_ff @(posedge read_clk) begin
        if (read_reset) begin
          sync_q[i] <= '0;
        end else begin
          sync_q[i] <= bus.write_pointer_grey;
        end
      end
    end else begin : g_rest
      always_ff @(posedge read_clk) begin
        if (read_reset) begin
          sync_q[i] <= '0;
        end else begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end
  end

  assign wptr_sync = sync_q[SYNC_STAGES-1];

  read_pointer_ctrl_gray2bin #(
    .SIZE (SIZE)
  ) u_gray2bin (
    .gray (wptr_sync),
    .bin  (wptr_bin)
  );

  // Flags use the stale synchronised pointer, so they can only err towards empty.
  always_comb begin
    do_read    = bus.read_inc & ~empty_q;
    bin_next   = bin_q + PW'(do_read);
    gray_next  = PW'(bin2gray(wide_ptr_t'(bin_next)));
    level_next = wptr_bin - bin_next;
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      bin_q          <= '0;
      gray_q         <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      bin_q          <= bin_next;
      gray_q         <= gray_next;
      level_q        <= level_next;
      empty_q        <= (gray_next == wptr_sync);
      almost_empty_q <= (level_next <= AE_LEVEL);
    end
  end

  assign bus.read_empty        = empty_q;
  assign bus.read_almost_empty = almost_empty_q;
  assign bus.read_address      = bin_q[SIZE-1:0];
  assign bus.read_pointer      = gray_q;
  assign bus.read_level        = level_q;

endmodule

// File: tb/tb_read_pointer_ctrl.sv
// Directed bench for read_pointer_ctrl (SIZE=4, SYNC_STAGES=2, ALMOST_EMPTY_LEVEL=1)
// with an expected-value queue drained by a negedge monitor.
module tb_read_pointer_ctrl;

  typedef struct packed {
    logic [7:0] id;
    logic       empty;
    logic       ae;
    logic [4:0] ptr;
    logic [3:0] addr;
    logic [4:0] level;
  } exp_t;

  logic read_clk;
  logic read_reset;

  read_pointer_ctrl_if #(.SIZE(4)) bus ();

  read_pointer_ctrl #(
    .SIZE               (4),
    .SYNC_STAGES        (2),
    .ALMOST_EMPTY_LEVEL (1)
  ) dut (
    .read_clk   (read_clk),
    .read_reset (read_reset),
    .bus        (bus)
  );

  // Gray codes of 0..31, written out by hand.
  logic [4:0] gtab [32] = '{
    5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
    5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
    5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
    5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10
  };

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Occupancy model in word counts: written words seen two edges late, words popped.
  int   m_s0    = 0;
  int   m_s1    = 0;
  int   m_rbin  = 0;
  int   m_level = 0;
  bit   m_empty = 1'b1;

  // ---------------- clock ----------------
  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  // ---------------- model + driver ----------------
  task automatic model_step(input bit rst, input bit inc, input int wbin, output exp_t e);
    bit rd;
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_rbin = 0; m_level = 0; m_empty = 1'b1;
    end else begin
      rd      = inc && !m_empty;
      m_rbin  = (m_rbin + (rd ? 1 : 0)) % 32;
      m_level = (m_s1 - m_rbin + 32) % 32;
      m_empty = (m_level == 0);
      m_s1    = m_s0;
      m_s0    = wbin % 32;
    end
    e.id    = 8'd0;
    e.empty = m_empty;
    e.ae    = (m_level <= 1);
    e.ptr   = gtab[m_rbin];
    e.addr  = 4'(m_rbin % 16);
    e.level = 5'(m_level);
  endtask

  task automatic drive(input bit rst, input bit inc, input int wbin, input exp_t e);
    read_reset             = rst;
    bus.read_inc           = inc;
    bus.write_pointer_grey = gtab[wbin % 32];
    exp_q.push_back(e);
    @(posedge read_clk);
    #1;
  endtask

  task automatic step(input bit rst, input bit inc, input int wbin, input int id);
    exp_t e;
    model_step(rst, inc, wbin, e);
    e.id = 8'(id);
    drive(rst, inc, wbin, e);
  endtask

  task automatic step_hand(input bit rst, input bit inc, input int wbin, input int id,
                           input bit he, input bit hae, input int hlevel, input int hrbin);
    exp_t e;
    model_step(rst, inc, wbin, e);
    e.id    = 8'(id);
    e.empty = he;
    e.ae    = hae;
    e.level = 5'(hlevel);
    e.ptr   = gtab[hrbin % 32];
    e.addr  = 4'(hrbin % 16);
    drive(rst, inc, wbin, e);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge read_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (bus.read_empty !== e.empty || bus.read_almost_empty !== e.ae ||
          bus.read_pointer !== e.ptr || bus.read_address !== e.addr ||
          bus.read_level !== e.level) begin
        miscompares++;
        $display("FAIL t%0d vec%0d: got empty=%b ae=%b ptr=%05b addr=%0d level=%0d, want empty=%b ae=%b ptr=%05b addr=%0d level=%0d",
                 e.id, vectors, bus.read_empty, bus.read_almost_empty, bus.read_pointer,
                 bus.read_address, bus.read_level, e.empty, e.ae, e.ptr, e.addr, e.level);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wb;
    int written;
    int occ;
    int guard;

    read_reset             = 1'b1;
    bus.read_inc           = 1'b0;
    bus.write_pointer_grey = '0;

    // 1: reset values
    step_hand(1, 0, 0, 1, 1, 1, 0, 0);
    step_hand(1, 0, 0, 1, 1, 1, 0, 0);

    // 2: one word arrives, empty falls on the third edge, then one pop
    step_hand(0, 0, 1, 2, 1, 1, 0, 0);
    step_hand(0, 0, 1, 2, 1, 1, 0, 0);
    step_hand(0, 0, 1, 2, 0, 1, 1, 0);
    step_hand(0, 1, 1, 2, 1, 1, 0, 1);

    // 3: pops while empty are ignored
    step_hand(1, 0, 0, 3, 1, 1, 0, 0);
    step_hand(0, 0, 0, 3, 1, 1, 0, 0);
    step_hand(0, 0, 0, 3, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) step_hand(0, 1, 0, 3, 1, 1, 0, 0);

    // 4: full FIFO, 16 back-to-back pops, then one rejected pop
    step_hand(0, 0, 16, 4, 1, 1, 0, 0);
    step_hand(0, 0, 16, 4, 1, 1, 0, 0);
    step_hand(0, 0, 16, 4, 0, 0, 16, 0);
    for (int k = 1; k <= 16; k++)
      step_hand(0, 1, 16, 4, (k == 16), ((16 - k) <= 1), 16 - k, k);
    step_hand(0, 1, 16, 4, 1, 1, 0, 16);

    // 5: 40 words with interleaved writes and pops, wrapping both pointers
    wb      = 16;
    written = 0;
    guard   = 0;
    while (!(written == 40 && m_rbin == wb) && guard < 400) begin
      occ = (wb - m_rbin + 32) % 32;
      if (written < 40 && (guard % 3) != 2 && occ < 16) begin
        wb = (wb + 1) % 32;
        written++;
      end
      step(0, (guard % 4) != 0, wb, 5);
      guard++;
    end
    if (guard >= 400) begin
      miscompares++;
      $display("FAIL t5 drain: %0d of 40 words written, model read ptr %0d vs write ptr %0d", written, m_rbin, wb);
    end
    for (int k = 0; k < 3; k++) step(0, 1, wb, 5);

    // 6: reset with level 5 and a pop pending, then recovery through the synchroniser
    step_hand(1, 0, 0, 6, 1, 1, 0, 0);
    step_hand(0, 0, 5, 6, 1, 1, 0, 0);
    step_hand(0, 0, 5, 6, 1, 1, 0, 0);
    step_hand(0, 0, 5, 6, 0, 0, 5, 0);
    step_hand(1, 1, 5, 6, 1, 1, 0, 0);
    step_hand(0, 0, 5, 6, 1, 1, 0, 0);
    step_hand(0, 0, 5, 6, 1, 1, 0, 0);
    step_hand(0, 0, 5, 6, 0, 0, 5, 0);
    step_hand(0, 1, 5, 6, 0, 0, 4, 1);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge read_clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
